// File: rtl/hazard_ctrl_unit.sv
// Hazard/stall controller for the 5-stage MIPS pipe: load-use and mult/div
// interlocks, data-memory freeze with timeout, branch flush, stall counter.
module hazard_ctrl_unit #(
    parameter int REG_AW    = 5,
    parameter int MD_CYCLES = 32,
    parameter int MEM_TO    = 64,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              rs_used_id,
    input  logic              rt_used_id,
    input  logic              md_id,
    input  logic              mfhilo_id,
    input  logic              dm_ren_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic              md_start_ex,
    input  logic              branch_taken_ex,
    input  logic              dm_req_mem,
    input  logic              dm_ack,
    input  logic              perf_clr,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              id_ex_hold,
    output logic              ex_mem_hold,
    output logic              if_id_clr,
    output logic              id_ex_clr,
    output logic              mem_wb_clr,
    output logic              md_busy,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam int MD_W = $clog2(MD_CYCLES + 1);
    localparam int WC_W = $clog2(MEM_TO + 1);

    typedef enum logic {M_IDLE, M_WAIT} mstate_t;

    logic [MD_W-1:0]   r_md_cnt;
    logic              r_md_busy;
    mstate_t           r_state;
    logic [WC_W-1:0]   r_wcnt;
    logic              r_mem_err;
    logic [PERF_W-1:0] r_stall_cnt;

    logic              w_lu_haz;
    logic              w_md_haz;
    logic              w_mem_stall;
    logic [WC_W-1:0]   w_wcnt_inc;

    assign w_lu_haz = dm_ren_ex && (rt_ex != '0) &&
                      ((rs_used_id && (rs_id == rt_ex)) || (rt_used_id && (rt_id == rt_ex)));
    assign w_md_haz    = (r_md_busy || md_start_ex) && (md_id || mfhilo_id);
    assign w_mem_stall = dm_req_mem && !dm_ack;

    // A frozen EX keeps any taken branch on its inputs, so it is acted on once the freeze ends.
    always_comb begin
        pc_hold     = 1'b0;
        if_id_hold  = 1'b0;
        id_ex_hold  = 1'b0;
        ex_mem_hold = 1'b0;
        if_id_clr   = 1'b0;
        id_ex_clr   = 1'b0;
        mem_wb_clr  = 1'b0;
        if (w_mem_stall) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
            mem_wb_clr  = 1'b1;
        end else if (branch_taken_ex) begin
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
        end else if (w_lu_haz || w_md_haz) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            id_ex_clr  = 1'b1;
        end
    end

    // The start is not accepted while the pipe is frozen; EX keeps presenting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt  <= '0;
            r_md_busy <= 1'b0;
        end else if (md_start_ex && !w_mem_stall) begin
            r_md_cnt  <= MD_W'(MD_CYCLES);
            r_md_busy <= 1'b1;
        end else if (r_md_cnt != '0) begin
            r_md_cnt  <= r_md_cnt - MD_W'(1);
            r_md_busy <= (r_md_cnt != MD_W'(1));
        end
    end

    assign w_wcnt_inc = (r_wcnt == WC_W'(MEM_TO)) ? r_wcnt : r_wcnt + WC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= M_IDLE;
            r_wcnt    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            if (w_mem_stall && (w_wcnt_inc == WC_W'(MEM_TO)))
                r_mem_err <= 1'b1;
            case (r_state)
                M_IDLE: begin
                    if (w_mem_stall) begin
                        r_state <= M_WAIT;
                        r_wcnt  <= w_wcnt_inc;
                    end
                end
                M_WAIT: begin
                    if (dm_ack || !dm_req_mem) begin
                        r_state <= M_IDLE;
                        r_wcnt  <= '0;
                    end else begin
                        r_wcnt <= w_wcnt_inc;
                    end
                end
                default: begin
                    r_state <= M_IDLE;
                    r_wcnt  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (perf_clr)
            r_stall_cnt <= '0;
        else if (pc_hold && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end

    assign md_busy   = r_md_busy;
    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with MD_CYCLES=4, MEM_TO=4, PERF_W=4.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_id, rt_id, rt_ex;
    logic       rs_used_id, rt_used_id, md_id, mfhilo_id;
    logic       dm_ren_ex, md_start_ex, branch_taken_ex;
    logic       dm_req_mem, dm_ack, perf_clr;
    logic       pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
    logic       if_id_clr, id_ex_clr, mem_wb_clr;
    logic       md_busy, mem_err;
    logic [3:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_clr, id_ex_clr, mem_wb_clr}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_FREEZE = 7'b1111001;
    localparam logic [6:0] C_FLUSH  = 7'b0000110;
    localparam logic [6:0] C_STALL  = 7'b1100010;

    logic [6:0] ctl;
    assign ctl = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_clr, id_ex_clr, mem_wb_clr};

    hazard_ctrl_unit #(.REG_AW(5), .MD_CYCLES(4), .MEM_TO(4), .PERF_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_id(rs_id), .rt_id(rt_id), .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
        .md_id(md_id), .mfhilo_id(mfhilo_id), .dm_ren_ex(dm_ren_ex), .rt_ex(rt_ex),
        .md_start_ex(md_start_ex), .branch_taken_ex(branch_taken_ex),
        .dm_req_mem(dm_req_mem), .dm_ack(dm_ack), .perf_clr(perf_clr),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold),
        .ex_mem_hold(ex_mem_hold), .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr),
        .mem_wb_clr(mem_wb_clr), .md_busy(md_busy), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        rs_id = 0; rt_id = 0; rt_ex = 0; rs_used_id = 0; rt_used_id = 0;
        md_id = 0; mfhilo_id = 0; dm_ren_ex = 0; md_start_ex = 0;
        branch_taken_ex = 0; dm_req_mem = 0; dm_ack = 0; perf_clr = 0;
    endtask

    // Advance one clock; inputs are then driven and outputs sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lu_in();
        dm_ren_ex = 1; rt_ex = 8; rs_id = 8; rs_used_id = 1;
    endtask

    initial begin
        idle_in();
        rst_n = 0;
        #12;
        chk("rst_ctl", 32'(ctl), 32'(C_NONE));
        chk("rst_busy", 32'(md_busy), 0);
        chk("rst_err", 32'(mem_err), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        rst_n = 1;

        step(); lu_in(); #1;
        chk("lu_ctl", 32'(ctl), 32'(C_STALL));
        step(); idle_in(); #1;
        chk("lu_after", 32'(ctl), 32'(C_NONE));
        chk("lu_cnt", 32'(stall_cnt), 1);

        lu_in(); rt_ex = 0; rs_id = 0; #1;
        chk("false_zero", 32'(ctl), 32'(C_NONE));
        lu_in(); rs_used_id = 0; #1;
        chk("false_unused", 32'(ctl), 32'(C_NONE));
        rt_id = 8; rt_used_id = 1; #1;
        chk("rt_match", 32'(ctl), 32'(C_STALL));
        step(); idle_in();
        lu_in(); branch_taken_ex = 1; #1;
        chk("br_over_lu", 32'(ctl), 32'(C_FLUSH));
        step(); idle_in(); #1;
        chk("br_cnt", 32'(stall_cnt), 2);

        md_start_ex = 1; mfhilo_id = 1; #1;
        chk("md_start_ctl", 32'(ctl), 32'(C_STALL));
        chk("md_start_busy", 32'(md_busy), 0);
        for (int i = 0; i < 4; i++) begin
            step(); md_start_ex = 0; #1;
            chk($sformatf("md_busy%0d", i), 32'(md_busy), 1);
            chk($sformatf("md_ctl%0d", i), 32'(ctl), 32'(C_STALL));
        end
        step(); #1;
        chk("md_done_busy", 32'(md_busy), 0);
        chk("md_done_ctl", 32'(ctl), 32'(C_NONE));
        chk("md_cnt", 32'(stall_cnt), 7);

        step(); idle_in();
        dm_req_mem = 1; branch_taken_ex = 1; md_start_ex = 1; #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("frz_ctl%0d", i), 32'(ctl), 32'(C_FREEZE));
            chk($sformatf("frz_busy%0d", i), 32'(md_busy), 0);
            step();
        end
        dm_ack = 1; #1;
        chk("ack_flush", 32'(ctl), 32'(C_FLUSH));
        chk("ack_busy", 32'(md_busy), 0);
        step(); idle_in(); #1;
        chk("md_late_load", 32'(md_busy), 1);
        chk("frz_cnt", 32'(stall_cnt), 10);
        chk("frz_err", 32'(mem_err), 0);
        for (int i = 0; i < 4; i++) step();
        #1;
        chk("md_late_drop", 32'(md_busy), 0);

        perf_clr = 1; lu_in();
        step(); idle_in(); #1;
        chk("perf_clr", 32'(stall_cnt), 0);

        dm_req_mem = 1;
        for (int i = 1; i <= 6; i++) begin
            step(); #1;
            if (i == 3) chk("to_before", 32'(mem_err), 0);
            if (i == 4) chk("to_set", 32'(mem_err), 1);
        end
        chk("to_ctl", 32'(ctl), 32'(C_FREEZE));
        dm_ack = 1; step(); idle_in(); #1;
        chk("to_sticky", 32'(mem_err), 1);
        chk("to_cnt", 32'(stall_cnt), 6);
        rst_n = 0; #1;
        chk("to_rst_err", 32'(mem_err), 0);
        chk("to_rst_cnt", 32'(stall_cnt), 0);
        rst_n = 1;

        step(); lu_in();
        for (int i = 0; i < 18; i++) step();
        #1;
        chk("sat_cnt", 32'(stall_cnt), 15);
        perf_clr = 1;
        step(); #1;
        chk("sat_clr", 32'(stall_cnt), 0);
        idle_in();

        md_start_ex = 1;
        step(); md_start_ex = 0; #1;
        chk("busy_pre_rst", 32'(md_busy), 1);
        rst_n = 0; #1;
        chk("busy_async_rst", 32'(md_busy), 0);
        chk("rst_all_ctl", 32'(ctl), 32'(C_NONE));
        #10 rst_n = 1;
        step(); #1;
        chk("busy_after_rst", 32'(md_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
